// File: rtl/ber_window_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ber_pkg
//  Description : Shared types, default sizing and helper functions for the
//                BER window counter and its LCD-side consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
package ber_pkg;

  // Counting state: bytes are discarded in WARMUP and accumulated in COUNT
  typedef enum logic [0:0] {
    WARMUP = 1'b0,
    COUNT  = 1'b1
  } state_t;

  localparam int C_DEF_DW          = 8;
  localparam int C_DEF_WINDOW_BITS = 1_048_576;
  localparam int C_DEF_SKIP_BYTES  = 64;
  localparam int C_DEF_GAP_TIMEOUT = 1024;

  // Ceiling log2; clog2(N+1) gives the width that can hold the value N
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage : ber_pkg
`default_nettype wire

// File: rtl/ber_window_counter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : ber_window_counter_if
//  Description : Raw sent/received byte tap plus the snapshot valid/ack
//                handshake towards the BER formatter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ber_window_counter_if #(
  parameter int DW = ber_pkg::C_DEF_DW,
  parameter int CW = ber_pkg::clog2(ber_pkg::C_DEF_WINDOW_BITS + 1)
);

  logic          valid_i;
  logic [DW-1:0] sent_data;
  logic [DW-1:0] recv_data;
  logic          snap_valid;
  logic          snap_ack;
  logic [CW-1:0] snap_bits;
  logic [CW-1:0] snap_errs;
  logic          snap_overrun;
  logic          in_sync;

  // Producer of raw bytes and consumer of snapshots
  modport master (
    output valid_i, sent_data, recv_data, snap_ack,
    input  snap_valid, snap_bits, snap_errs, snap_overrun, in_sync
  );

  // The counter itself
  modport slave (
    input  valid_i, sent_data, recv_data, snap_ack,
    output snap_valid, snap_bits, snap_errs, snap_overrun, in_sync
  );

endinterface : ber_window_counter_if
`default_nettype wire

// File: rtl/ber_window_counter_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : popcount
//  Description : Combinational population count of a DW-bit vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount #(
  parameter int DW = ber_pkg::C_DEF_DW,
  parameter int PW = ber_pkg::clog2(DW + 1)
) (
  input  wire logic [DW-1:0] i_diff,
  output logic      [PW-1:0] o_pop
);

  // Sum the set bits of the difference vector
  always_comb begin
    o_pop = '0;
    for (int i = 0; i < DW; i++) begin
      o_pop = o_pop + PW'(i_diff[i]);
    end
  end

endmodule : popcount
`default_nettype wire

// File: rtl/ber_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ber_window_counter
//  Description : Bit-error counter over fixed windows of raw sent/received
//                bytes. Three-stage pipeline (xor, popcount, accumulate),
//                warm-up discard after start/clear/link gap, and a
//                valid/ack snapshot register with sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module ber_window_counter
  import ber_pkg::*;
#(
  parameter int DW          = C_DEF_DW,
  parameter int WINDOW_BITS = C_DEF_WINDOW_BITS,
  parameter int CW          = clog2(WINDOW_BITS + 1),
  parameter int SKIP_BYTES  = C_DEF_SKIP_BYTES,
  parameter int GAP_TIMEOUT = C_DEF_GAP_TIMEOUT
) (
  input  wire logic           CLK,
  input  wire logic           nRST,
  input  wire logic           clear,
  ber_window_counter_if.slave bus
);

  localparam int PW  = clog2(DW + 1);
  // Skip counter only ever holds 0..SKIP_BYTES-1, gap counter 0..GAP_TIMEOUT-1
  localparam int SKW = (SKIP_BYTES  > 1) ? clog2(SKIP_BYTES)  : 1;
  localparam int GW  = (GAP_TIMEOUT > 1) ? clog2(GAP_TIMEOUT) : 1;

  localparam logic [CW-1:0]  c_WIN       = CW'(WINDOW_BITS);
  localparam logic [CW-1:0]  c_DW        = CW'(DW);
  localparam logic [SKW-1:0] c_SKIP_LAST = SKW'(SKIP_BYTES - 1);
  localparam logic [GW-1:0]  c_GAP_LAST  = GW'(GAP_TIMEOUT - 1);

  // Pipeline registers
  logic [DW-1:0]  r_diff;
  logic           r_v1;
  logic [PW-1:0]  r_pop;
  logic           r_v2;
  logic [PW-1:0]  w_pop;

  // Accumulation state
  state_t         r_state;
  logic           r_in_sync;
  logic [SKW-1:0] r_skip_cnt;
  logic [GW-1:0]  r_gap_cnt;
  logic [CW-1:0]  r_bit_acc;
  logic [CW-1:0]  r_err_acc;
  logic           r_evt;
  logic [CW-1:0]  r_evt_errs;

  // Snapshot register
  logic           r_snap_valid;
  logic [CW-1:0]  r_snap_bits;
  logic [CW-1:0]  r_snap_errs;
  logic           r_snap_overrun;

  logic [CW-1:0]  w_bit_next;
  logic [CW-1:0]  w_err_next;

  assign w_bit_next = r_bit_acc + c_DW;
  assign w_err_next = r_err_acc + CW'(r_pop);

  // P1: difference of sent and received byte
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_diff <= '0;
      r_v1   <= 1'b0;
    end else if (clear) begin
      r_diff <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_diff <= bus.sent_data ^ bus.recv_data;
      r_v1   <= bus.valid_i;
    end
  end

  popcount #(
    .DW (DW),
    .PW (PW)
  ) u_popcount (
    .i_diff (r_diff),
    .o_pop  (w_pop)
  );

  // P2: error bits in the byte
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pop <= '0;
      r_v2  <= 1'b0;
    end else if (clear) begin
      r_pop <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_pop <= w_pop;
      r_v2  <= r_v1;
    end
  end

  // P3: warm-up skipping, window accumulation and link-gap abort
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= WARMUP;
      r_in_sync  <= 1'b0;
      r_skip_cnt <= '0;
      r_gap_cnt  <= '0;
      r_bit_acc  <= '0;
      r_err_acc  <= '0;
      r_evt      <= 1'b0;
      r_evt_errs <= '0;
    end else if (clear) begin
      r_state    <= WARMUP;
      r_in_sync  <= 1'b0;
      r_skip_cnt <= '0;
      r_gap_cnt  <= '0;
      r_bit_acc  <= '0;
      r_err_acc  <= '0;
      r_evt      <= 1'b0;
      r_evt_errs <= '0;
    end else begin
      r_evt <= 1'b0;
      case (r_state)
        WARMUP: begin
          if (SKIP_BYTES == 0) begin
            r_state   <= COUNT;
            r_in_sync <= 1'b1;
          end else if (r_v2) begin
            // The byte that completes the warm-up is itself discarded
            if (r_skip_cnt == c_SKIP_LAST) begin
              r_skip_cnt <= '0;
              r_state    <= COUNT;
              r_in_sync  <= 1'b1;
            end else begin
              r_skip_cnt <= r_skip_cnt + SKW'(1);
            end
          end
        end
        COUNT: begin
          if (r_v2) begin
            r_gap_cnt <= '0;
            if (w_bit_next == c_WIN) begin
              // Window complete: hand the total to the snapshot stage
              r_evt      <= 1'b1;
              r_evt_errs <= w_err_next;
              r_bit_acc  <= '0;
              r_err_acc  <= '0;
            end else begin
              r_bit_acc <= w_bit_next;
              r_err_acc <= w_err_next;
            end
          end else if (r_gap_cnt == c_GAP_LAST) begin
            // Link went quiet: drop the partial window and resynchronise
            r_gap_cnt <= '0;
            r_bit_acc <= '0;
            r_err_acc <= '0;
            r_state   <= WARMUP;
            r_in_sync <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state   <= WARMUP;
          r_in_sync <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot register: load on window completion, release on ack
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_snap_valid   <= 1'b0;
      r_snap_bits    <= '0;
      r_snap_errs    <= '0;
      r_snap_overrun <= 1'b0;
    end else if (clear) begin
      // Data is left in place so the display keeps its last reading
      r_snap_valid   <= 1'b0;
      r_snap_overrun <= 1'b0;
    end else if (r_evt) begin
      r_snap_valid <= 1'b1;
      r_snap_bits  <= c_WIN;
      r_snap_errs  <= r_evt_errs;
      // Overwriting only counts as overrun when the old one was not taken
      if (r_snap_valid && !bus.snap_ack) begin
        r_snap_overrun <= 1'b1;
      end
    end else if (r_snap_valid && bus.snap_ack) begin
      r_snap_valid <= 1'b0;
    end
  end

  assign bus.snap_valid   = r_snap_valid;
  assign bus.snap_bits    = r_snap_bits;
  assign bus.snap_errs    = r_snap_errs;
  assign bus.snap_overrun = r_snap_overrun;
  assign bus.in_sync      = r_in_sync;

endmodule : ber_window_counter
`default_nettype wire

// File: tb/tb_ber_window_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ber_window_counter
//  Description : Self-checking bench for ber_window_counter with a small
//                window (64 bits), 2-byte warm-up and 16-cycle gap timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ber_window_counter;

  localparam int c_DW   = 8;
  localparam int c_WB   = 64;
  localparam int c_CW   = 7;
  localparam int c_SKIP = 2;
  localparam int c_GAP  = 16;

  typedef struct {
    logic [7:0] mask;
    int         exp_errs;
  } vec_t;

  logic CLK;
  logic nRST;
  logic clear;

  int n_checks;
  int n_fail;
  int exp_q[$];
  vec_t vecs[6];

  ber_window_counter_if #(.DW(c_DW), .CW(c_CW)) bus ();

  ber_window_counter #(
    .DW          (c_DW),
    .WINDOW_BITS (c_WB),
    .CW          (c_CW),
    .SKIP_BYTES  (c_SKIP),
    .GAP_TIMEOUT (c_GAP)
  ) dut (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] mask);
    logic [7:0] s;
    s = 8'($urandom);
    bus.valid_i   = 1'b1;
    bus.sent_data = s;
    bus.recv_data = s ^ mask;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_n(input int n, input logic [7:0] mask);
    for (int i = 0; i < n; i++) send(mask);
  endtask

  // Pop the scoreboard and compare once snap_valid is seen (bounded wait)
  task automatic wait_snap(input string name, input int max_cyc);
    int n;
    int e;
    n = 0;
    while (bus.snap_valid !== 1'b1 && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    if (bus.snap_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: snap_valid got 0 within %0d cycles, required 1", name, max_cyc);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: snapshot seen with empty scoreboard, got 1 required 0", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " bits"}, 32'(bus.snap_bits), 32'(c_WB));
      check({name, " errs"}, 32'(bus.snap_errs), 32'(e));
    end
  endtask

  // Exact latency: valid must appear on the 3rd edge after the last byte's sample
  task automatic window_tail(input string name);
    idle(2);
    check({name, " no early valid"}, 32'(bus.snap_valid), 32'd0);
    idle(1);
    check({name, " valid latency"}, 32'(bus.snap_valid), 32'd1);
    wait_snap(name, 2);
  endtask

  task automatic do_ack(input string name);
    bus.snap_ack = 1'b1;
    @(negedge CLK);
    bus.snap_ack = 1'b0;
    check({name, " valid after ack"}, 32'(bus.snap_valid), 32'd0);
  endtask

  initial begin
    int rexp;
    logic [7:0] m;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{8'h01, 8};
    vecs[1] = '{8'hFF, 64};
    vecs[2] = '{8'h00, 0};
    vecs[3] = '{8'h0F, 32};
    vecs[4] = '{8'h80, 8};
    vecs[5] = '{8'hA5, 32};

    nRST = 1'b0;
    clear = 1'b0;
    bus.valid_i = 1'b0;
    bus.sent_data = '0;
    bus.recv_data = '0;
    bus.snap_ack = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset snap_valid", 32'(bus.snap_valid), 32'd0);
    check("reset snap_bits", 32'(bus.snap_bits), 32'd0);
    check("reset snap_errs", 32'(bus.snap_errs), 32'd0);
    check("reset overrun", 32'(bus.snap_overrun), 32'd0);
    check("reset in_sync", 32'(bus.in_sync), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // 1: warm-up then one clean window
    send_n(2, 8'hFF);
    send(8'h00);
    check("t1 in_sync before", 32'(bus.in_sync), 32'd0);
    send(8'h00);
    check("t1 in_sync 3 cycles", 32'(bus.in_sync), 32'd1);
    send_n(6, 8'h00);
    exp_q.push_back(0);
    window_tail("t1 window");
    do_ack("t1");

    // 2: table of fixed-mask windows, then one random-mask window
    for (int v = 0; v < 6; v++) begin
      send_n(8, vecs[v].mask);
      exp_q.push_back(vecs[v].exp_errs);
      window_tail($sformatf("t2 vec%0d", v));
      do_ack($sformatf("t2 vec%0d", v));
    end
    rexp = 0;
    for (int i = 0; i < 8; i++) begin
      m = 8'($urandom);
      rexp += $countones(m);
      send(m);
    end
    exp_q.push_back(rexp);
    window_tail("t2 random");
    do_ack("t2 random");

    // 3: two windows without ack -> overrun
    send_n(8, 8'h01);
    exp_q.push_back(8);
    window_tail("t3 first");
    send_n(8, 8'h03);
    exp_q.push_back(16);
    idle(3);
    wait_snap("t3 second", 0);
    check("t3 overrun", 32'(bus.snap_overrun), 32'd1);
    check("t3 valid", 32'(bus.snap_valid), 32'd1);
    do_ack("t3");
    check("t3 overrun sticky", 32'(bus.snap_overrun), 32'd1);

    // 4: partial window then link gap
    check("t4 in_sync start", 32'(bus.in_sync), 32'd1);
    send_n(4, 8'h00);
    idle(17);
    check("t4 in_sync before timeout", 32'(bus.in_sync), 32'd1);
    idle(1);
    check("t4 in_sync after timeout", 32'(bus.in_sync), 32'd0);
    send_n(2, 8'hFF);
    send_n(8, 8'h01);
    exp_q.push_back(8);
    window_tail("t4 window");
    do_ack("t4");
    check("t4 overrun sticky", 32'(bus.snap_overrun), 32'd1);

    // 6a: clear mid-window while a byte is valid
    send_n(4, 8'h00);
    clear = 1'b1;
    send(8'hFF);
    clear = 1'b0;
    bus.valid_i = 1'b0;
    check("clrA overrun", 32'(bus.snap_overrun), 32'd0);
    check("clrA in_sync", 32'(bus.in_sync), 32'd0);
    check("clrA bits held", 32'(bus.snap_bits), 32'd64);
    check("clrA errs held", 32'(bus.snap_errs), 32'd8);
    send_n(2, 8'hFF);
    send_n(8, 8'h0F);
    exp_q.push_back(32);
    window_tail("clrA window");

    // 5: ack in the exact cycle the next snapshot loads
    send_n(8, 8'h01);
    idle(2);
    check("t5 old errs", 32'(bus.snap_errs), 32'd32);
    bus.snap_ack = 1'b1;
    @(negedge CLK);
    bus.snap_ack = 1'b0;
    check("t5 valid stays", 32'(bus.snap_valid), 32'd1);
    check("t5 new errs", 32'(bus.snap_errs), 32'd8);
    check("t5 no overrun", 32'(bus.snap_overrun), 32'd0);

    // 6b: clear while snap_valid is high
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    check("clrB valid", 32'(bus.snap_valid), 32'd0);
    check("clrB bits held", 32'(bus.snap_bits), 32'd64);
    check("clrB errs held", 32'(bus.snap_errs), 32'd8);
    send_n(2, 8'h00);
    send_n(8, 8'h3C);
    exp_q.push_back(32);
    window_tail("clrB window");

    // 6c: asynchronous reset while snap_valid is high
    #3 nRST = 1'b0;
    #1;
    check("rst valid", 32'(bus.snap_valid), 32'd0);
    check("rst bits", 32'(bus.snap_bits), 32'd0);
    check("rst errs", 32'(bus.snap_errs), 32'd0);
    check("rst in_sync", 32'(bus.in_sync), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    send_n(2, 8'h00);
    send_n(8, 8'hFF);
    exp_q.push_back(64);
    window_tail("rst window");
    do_ack("rst");

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ber_window_counter
`default_nettype wire

// File: doc/ber_window_counter.md
Name: ber_window_counter

Overview:
- Sits between the comm datapath's raw tap (valid_raw / raw_send_d / raw_recv) and the LCD BER formatter.
- Compares each sent/received raw symbol byte and counts bit errors over fixed-size windows.
- Hands each completed window's (bits, errors) snapshot downstream through a valid/ack handshake.
- Discards a warm-up run of bytes after start and after link gaps.

Parameters:
- DW, 8, raw byte width in bits.
- WINDOW_BITS, 1_048_576, bits per window; must be a multiple of DW.
- CW, clog2(WINDOW_BITS+1), width of the snapshot counters.
- SKIP_BYTES, 64, valid bytes discarded after reset, clear or timeout.
- GAP_TIMEOUT, 1024, consecutive cycles without valid_i, while in COUNT, that abort the current window.

Ports:
- CLK  in  1  clkcomm domain clock; all logic on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart; returns to WARMUP.
- valid_i  in  1  sent_data/recv_data qualify this cycle.
- sent_data  in  DW  transmitted raw byte.
- recv_data  in  DW  received raw byte, already delay-aligned.
- snap_valid  out  1  snapshot available.
- snap_ack  in  1  consumer accepts the snapshot.
- snap_bits  out  CW  bits in the snapshot window.
- snap_errs  out  CW  error bits in the snapshot window.
- snap_overrun  out  1  sticky: an unacked snapshot was overwritten.
- in_sync  out  1  high while in COUNT.

Behaviour:
- Reset (nRST low): all outputs 0, accumulators 0, pipeline valids 0, state WARMUP, skip and gap counters 0.
- Pipeline:
  - P1 registers diff = sent_data ^ recv_data and v1 = valid_i.
  - P2 registers pop = popcount(diff), width clog2(DW+1), and v2 = v1.
  - P3 acts on v2. Total latency from a valid_i byte to its effect at P3 is 3 cycles.
- States: WARMUP, COUNT.
  - WARMUP: each v2 increments skip_cnt. On the v2 where skip_cnt == SKIP_BYTES-1: skip_cnt←0, go to COUNT. That byte is still discarded. SKIP_BYTES=0 means go to COUNT on the first cycle.
  - COUNT: on v2, if bit_acc + DW == WINDOW_BITS:
    - snapshot ← (WINDOW_BITS, err_acc + pop);
    - bit_acc←0, err_acc←0 in the same cycle;
    - snap_valid←1 on the next cycle edge, i.e. visible 1 cycle after the P3 event.
  - COUNT, otherwise on v2: bit_acc += DW, err_acc += pop.
  - Gap: gap_cnt counts cycles with v2=0 in COUNT and resets on v2. When gap_cnt reaches GAP_TIMEOUT-1: bit_acc/err_acc←0 (partial window dropped), go to WARMUP. Any pending snapshot is retained.
- Handshake:
  - snap_bits/snap_errs are stable while snap_valid && !snap_ack.
  - snap_valid && snap_ack clears snap_valid next cycle.
  - If a new snapshot is produced in the same cycle as an ack: the new data loads, snap_valid stays 1, no overrun.
  - If a new snapshot is produced while snap_valid=1 without ack: the new data overwrites and snap_overrun←1.
  - snap_ack while snap_valid=0 is ignored.
- clear:
  - Highest priority over valid_i, v1/v2, snapshot and ack in that cycle.
  - Flushes v1/v2, zeros accumulators, skip_cnt and gap_cnt, state←WARMUP.
  - snap_valid←0, snap_overrun←0; snap_bits/snap_errs hold their last values.
- Arithmetic: err_acc ≤ bit_acc < WINDOW_BITS, so CW never overflows and no saturation logic is needed. Width of pop is zero-extended to CW.
- in_sync = (state == COUNT), registered.

Decomposition:
- Package ber_pkg: state enum (WARMUP, COUNT), default DW/WINDOW_BITS/SKIP_BYTES/GAP_TIMEOUT, and a clog2 function for CW and the popcount width.
- Sub-module popcount: parameter DW, purely combinational diff→count, used in P2 and reusable by the LCD side.

Test Plan (DW=8, WINDOW_BITS=64, SKIP_BYTES=2, GAP_TIMEOUT=16):
1. Reset, then 2 bytes with recv=~sent, then 8 bytes with recv=sent, back-to-back.
   - in_sync=1 three cycles after the 2nd byte.
   - snap_valid rises 4 cycles after the 10th byte with snap_bits=64, snap_errs=0.
2. After warm-up, 8 bytes recv=sent^8'h01 → snap_errs=8. The next 8 bytes recv=sent^8'hFF → snap_errs=64.
3. snap_ack held 0 across two windows (errs 8, then 16).
   - snap_errs=16, snap_overrun=1, snap_valid=1.
   - An ack drops snap_valid; snap_overrun stays 1 until clear.
4. After warm-up, 4 correct bytes, then 16 idle cycles.
   - in_sync=0 and the partial window is dropped.
   - 2 further bytes are skipped; the next snapshot covers exactly the following 8 bytes (errs per stimulus).
5. Ack asserted in the exact cycle a new window completes → snap_valid stays 1, new values appear, snap_overrun=0.
6. clear asserted with valid_i=1 mid-window, and separately nRST pulsed while snap_valid=1.
   - All outputs return to 0, with snap_bits/snap_errs held on clear.
   - The next snapshot needs SKIP_BYTES+8 fresh bytes.
